calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
Sequencing controller for the keypad calculator datapath. It turns debounced keypad events into two 2-digit BCD operands and an operator code, then starts the arithmetic unit with a start/done handshake. It also drives the display-mode selects. It sits between keypad_scan and the num_calculator → BCD → FTSD display chain, and replaces the purely combinational key-to-operand path with an explicit, timeout-protected sequence.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles to wait for calc_done before flagging an error (must be ≥1)
DEBOUNCE_CYCLES, 4, consecutive cycles pressed must be high before a press is accepted (used only when KEY_DEBOUNCE_EN is defined)

Ports:
clk  in  1  scan-domain clock
rst  in  1  synchronous, active-high reset
key  in  4  key code from the scanner: 0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 unused, 15 clear
pressed  in  1  key-valid level from the scanner
calc_done  in  1  arithmetic unit result valid; sampled only in S_WAIT
numA  out  8  operand A, BCD {tens, units}
numB  out  8  operand B, BCD {tens, units}
calculation  out  2  operator code: 00 add, 01 sub, 10 mul
calc_start  out  1  one-cycle start pulse to the arithmetic unit
state  out  2  FSM state: 00 S_A, 01 S_B, 10 S_WAIT, 11 S_RES
state_disp  out  1  display select: 0 operand view, 1 result view
err  out  1  sticky timeout error flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high. All outputs are registered.
- Reset values: numA=0, numB=0, calculation=00, calc_start=0, state=S_A, state_disp=0, err=0. The timeout counter and the pressed history register are also cleared.
- Press event (evt): in cycle N, pressed=1 and the registered previous pressed=0. A held key produces exactly one evt. The key is sampled in cycle N and its effect is visible on the outputs in cycle N+1.
- Clear key (15): active in any state. Sets numA, numB, calculation, err and the counter to 0, state=S_A, state_disp=0, calc_start=0.
- Priority when events coincide: rst > clear evt > calc_done > timeout.
- S_A:
  - digit d: numA <= {numA[3:0], d}; the old tens digit is discarded.
  - operator key: calculation <= op code, numB <= 0, go to S_B.
  - '=' and key 14: ignored.
- S_B:
  - digit d: numB <= {numB[3:0], d}.
  - operator key: replaces calculation; stays in S_B.
  - '=': calc_start=1 for exactly one cycle (cycle N+1); go to S_WAIT; counter <= 0.
- S_WAIT:
  - All non-clear keys are ignored. Operands and calculation stay frozen.
  - Counter increments each cycle.
  - calc_done=1: go to S_RES, state_disp=1, err stays 0. The earliest accepted done is the first S_WAIT cycle (the cycle calc_start is high).
  - Counter reaches TIMEOUT_CYCLES-1 with no done: err=1, go to S_RES, state_disp=1.
  - A done and a timeout in the same cycle: done wins, err=0.
- S_RES:
  - digit d: numA <= {4'h0, d}, numB <= 0, calculation <= 00, err <= 0, state_disp <= 0, go to S_A.
  - operator key, '=' and key 14: ignored.
- calc_done outside S_WAIT: ignored.
- calc_start is never high outside the single cycle after the '=' evt.
- Reset mid-operation: returns to the reset values on the next edge, with no residual start pulse.
- state_disp is 1 only in S_RES.

Optional Feature:
KEY_DEBOUNCE_EN:
- Defined: evt fires once pressed has been high for DEBOUNCE_CYCLES consecutive cycles, while the debounce counter saturates. Any low cycle resets the counter, and a new evt needs pressed to go low again. The key is sampled in the accepting cycle.
- Undefined: evt is the plain rising edge described above, and DEBOUNCE_CYCLES is unused.

Test Plan:
- Basic add: keys 1,2,+,3,4,= with a release between each; calc_done 3 cycles after calc_start → numA=8'h12, numB=8'h34, calculation=00, one calc_start pulse, state 00→01→10→11, state_disp=1, err=0.
- Held key: key 7 held high for 20 cycles in S_A → numA=8'h07, not 8'h77.
- Digit overflow and operator replace: keys 9,8,7,*,-,5 → numA=8'h87, calculation=01, numB=8'h05, state=S_B.
- Timeout: TIMEOUT_CYCLES=8, '=' pressed and calc_done never asserted → err=1 and state=S_RES after 8 S_WAIT cycles; a later digit 4 → numA=8'h04, err=0, state=S_A.
- Clear vs done: clear evt in the same cycle as calc_done in S_WAIT → state=S_A, all outputs zero, state_disp=0.
- Debounce (KEY_DEBOUNCE_EN, DEBOUNCE_CYCLES=4): pressed glitch of 3 cycles → no change; a 4-cycle press of key 2 → numA=8'h02 after the 4th cycle.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Keypad calculator sequencer: builds BCD operands, starts the ALU, guards done with a timeout.
// Optional KEY_DEBOUNCE_EN: accept a press only after DEBOUNCE_CYCLES steady high cycles.
module calc_seq_ctrl #(
   parameter int TIMEOUT_CYCLES  = 255,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key,
   input  logic       pressed,
   input  logic       calc_done,
   output logic [7:0] numA,
   output logic [7:0] numB,
   output logic [1:0] calculation,
   output logic       calc_start,
   output logic [1:0] state,
   output logic       state_disp,
   output logic       err
);

   typedef enum logic [1:0] {
      S_A    = 2'b00,
      S_B    = 2'b01,
      S_WAIT = 2'b10,
      S_RES  = 2'b11
   } state_t;

`ifdef KEY_DEBOUNCE_EN
   localparam int DB_N = DEBOUNCE_CYCLES;
`else
   // one cycle of history: plain rising-edge detect
   localparam int DB_N = DEBOUNCE_CYCLES - DEBOUNCE_CYCLES + 1;
`endif
   localparam int DBW = $clog2(DB_N + 1);
   localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

   state_t         state_q, state_d;
   logic [7:0]     num_a_q, num_a_d;
   logic [7:0]     num_b_q, num_b_d;
   logic [1:0]     calc_q, calc_d;
   logic           start_q, start_d;
   logic           disp_q, disp_d;
   logic           err_q, err_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [DBW-1:0] db_q, db_d;

   logic evt;
   logic is_digit;
   logic is_op;
   logic is_eq;
   logic is_clr;

   assign evt      = pressed && (db_q == DBW'(DB_N - 1));
   assign is_digit = (key <= 4'd9);
   assign is_op    = (key >= 4'd10) && (key <= 4'd12);
   assign is_eq    = (key == 4'd13);
   assign is_clr   = (key == 4'd15);

   always_comb begin
      if (!pressed)
         db_d = '0;
      else if (db_q != DBW'(DB_N))
         db_d = db_q + DBW'(1);
      else
         db_d = db_q;
   end

   always_comb begin
      state_d = state_q;
      num_a_d = num_a_q;
      num_b_d = num_b_q;
      calc_d  = calc_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;

      if (evt && is_clr) begin
         state_d = S_A;
         num_a_d = '0;
         num_b_d = '0;
         calc_d  = '0;
         err_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_A: begin
               if (evt) begin
                  unique case (1'b1)
                     is_digit: num_a_d = {num_a_q[3:0], key};
                     is_op: begin
                        calc_d  = key[1:0] - 2'b10;
                        num_b_d = '0;
                        state_d = S_B;
                     end
                     default: ;
                  endcase
               end
            end
            S_B: begin
               if (evt) begin
                  unique case (1'b1)
                     is_digit: num_b_d = {num_b_q[3:0], key};
                     is_op:    calc_d  = key[1:0] - 2'b10;
                     is_eq: begin
                        start_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                     end
                     default: ;
                  endcase
               end
            end
            S_WAIT: begin
               cnt_d = cnt_q + CW'(1);
               if (calc_done) begin
                  state_d = S_RES;
               end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  err_d   = 1'b1;
                  state_d = S_RES;
               end
            end
            S_RES: begin
               if (evt && is_digit) begin
                  num_a_d = {4'h0, key};
                  num_b_d = '0;
                  calc_d  = '0;
                  err_d   = 1'b0;
                  state_d = S_A;
               end
            end
            default: ;
         endcase
      end

      disp_d = (state_d == S_RES);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_A;
         num_a_q <= '0;
         num_b_q <= '0;
         calc_q  <= '0;
         start_q <= 1'b0;
         disp_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         db_q    <= '0;
      end else begin
         state_q <= state_d;
         num_a_q <= num_a_d;
         num_b_q <= num_b_d;
         calc_q  <= calc_d;
         start_q <= start_d;
         disp_q  <= disp_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
      end
   end

   assign numA        = num_a_q;
   assign numB        = num_b_q;
   assign calculation = calc_q;
   assign calc_start  = start_q;
   assign state       = state_q;
   assign state_disp  = disp_q;
   assign err         = err_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with TIMEOUT_CYCLES=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_calc_seq_ctrl;

`ifdef KEY_DEBOUNCE_EN
   localparam int HOLD = 4;
`else
   localparam int HOLD = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key;
   logic       pressed;
   logic       calc_done;
   logic [7:0] numA;
   logic [7:0] numB;
   logic [1:0] calculation;
   logic       calc_start;
   logic [1:0] state;
   logic       state_disp;
   logic       err;

   int tests = 0;
   int fails = 0;

   calc_seq_ctrl #(
      .TIMEOUT_CYCLES (8),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key        (key),
      .pressed    (pressed),
      .calc_done  (calc_done),
      .numA       (numA),
      .numB       (numB),
      .calculation(calculation),
      .calc_start (calc_start),
      .state      (state),
      .state_disp (state_disp),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic press(input logic [3:0] k);
      key = k;
      pressed = 1'b1;
      repeat (HOLD) tick();
      pressed = 1'b0;
      repeat (2) tick();
   endtask

   // leaves pressed high at the edge where '=' was accepted
   task automatic fire_eq();
      key = 4'd13;
      pressed = 1'b1;
      repeat (HOLD) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      key = 4'd0;
      pressed = 1'b0;
      calc_done = 1'b0;
      repeat (3) tick();
      tests++;
      if ({numA, numB, calculation, calc_start, state, state_disp, err} !== 23'd0) begin
         fails++;
         $display("FAIL reset_outputs got A=%h B=%h c=%b s=%b st=%b d=%b e=%b exp all zero",
                  numA, numB, calculation, calc_start, state, state_disp, err);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_add();
      int starts;
      press(4'd1);
      tests++;
      if (numA !== 8'h01) begin fails++; $display("FAIL add_a1 got %h exp 01", numA); end
      press(4'd2);
      tests++;
      if (numA !== 8'h12) begin fails++; $display("FAIL add_a12 got %h exp 12", numA); end
      tests++;
      if (state !== 2'b00) begin fails++; $display("FAIL add_stA got %b exp 00", state); end
      press(4'd10);
      tests++;
      if ({state, calculation, numB} !== {2'b01, 2'b00, 8'h00}) begin
         fails++;
         $display("FAIL add_op got st=%b c=%b B=%h exp 01 00 00", state, calculation, numB);
      end
      press(4'd3);
      press(4'd4);
      tests++;
      if (numB !== 8'h34) begin fails++; $display("FAIL add_b34 got %h exp 34", numB); end
      fire_eq();
      starts = 0;
      tests++;
      if ({calc_start, state} !== 3'b110) begin
         fails++;
         $display("FAIL add_start got s=%b st=%b exp 1 10", calc_start, state);
      end
      if (calc_start === 1'b1) starts++;
      pressed = 1'b0;
      tick();
      if (calc_start === 1'b1) starts++;
      tick();
      if (calc_start === 1'b1) starts++;
      tests++;
      if (state !== 2'b10) begin fails++; $display("FAIL add_wait got %b exp 10", state); end
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      if (calc_start === 1'b1) starts++;
      tests++;
      if (starts !== 1) begin fails++; $display("FAIL add_pulses got %0d exp 1", starts); end
      tests++;
      if ({state, state_disp, err} !== 4'b1110) begin
         fails++;
         $display("FAIL add_res got st=%b d=%b e=%b exp 11 1 0", state, state_disp, err);
      end
      tests++;
      if ({numA, numB, calculation} !== {8'h12, 8'h34, 2'b00}) begin
         fails++;
         $display("FAIL add_frozen got A=%h B=%h c=%b exp 12 34 00", numA, numB, calculation);
      end
   endtask

   task automatic test_res_digit();
      press(4'd5);
      tests++;
      if ({numA, numB, calculation, state, state_disp, err} !== {8'h05, 8'h00, 6'b000000}) begin
         fails++;
         $display("FAIL res_digit got A=%h B=%h c=%b st=%b d=%b e=%b exp 05 00 00 00 0 0",
                  numA, numB, calculation, state, state_disp, err);
      end
   endtask

   task automatic test_held_key();
      press(4'd15);
      tests++;
      if ({numA, numB, state} !== 18'd0) begin
         fails++;
         $display("FAIL held_clear got A=%h B=%h st=%b exp 00 00 00", numA, numB, state);
      end
      key = 4'd7;
      pressed = 1'b1;
      repeat (20) tick();
      pressed = 1'b0;
      tick();
      tests++;
      if (numA !== 8'h07) begin fails++; $display("FAIL held_7 got %h exp 07", numA); end
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      tests++;
      if ({state, state_disp} !== 3'b000) begin
         fails++;
         $display("FAIL stray_done got st=%b d=%b exp 00 0", state, state_disp);
      end
   endtask

   task automatic test_overflow();
      press(4'd15);
      press(4'd9);
      press(4'd8);
      press(4'd7);
      tests++;
      if (numA !== 8'h87) begin fails++; $display("FAIL ovf_a got %h exp 87", numA); end
      press(4'd12);
      tests++;
      if ({state, calculation} !== 4'b0110) begin
         fails++;
         $display("FAIL ovf_mul got st=%b c=%b exp 01 10", state, calculation);
      end
      press(4'd11);
      press(4'd5);
      tests++;
      if ({numA, calculation, numB, state} !== {8'h87, 2'b01, 8'h05, 2'b01}) begin
         fails++;
         $display("FAIL ovf_final got A=%h c=%b B=%h st=%b exp 87 01 05 01",
                  numA, calculation, numB, state);
      end
   endtask

   task automatic test_timeout();
      fire_eq();
      pressed = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tests++;
         if ({state, calc_start, err} !== {2'b10, (i == 0), 1'b0}) begin
            fails++;
            $display("FAIL to_wait%0d got st=%b s=%b e=%b", i, state, calc_start, err);
         end
         tick();
      end
      tests++;
      if ({state, state_disp, err} !== 4'b1111) begin
         fails++;
         $display("FAIL to_err got st=%b d=%b e=%b exp 11 1 1", state, state_disp, err);
      end
      press(4'd13);
      tests++;
      if ({state, err} !== 3'b111) begin
         fails++;
         $display("FAIL to_eq_ign got st=%b e=%b exp 11 1", state, err);
      end
      press(4'd4);
      tests++;
      if ({numA, numB, err, state, state_disp} !== {8'h04, 8'h00, 4'b0000}) begin
         fails++;
         $display("FAIL to_recover got A=%h B=%h e=%b st=%b d=%b exp 04 00 0 00 0",
                  numA, numB, err, state, state_disp);
      end
   endtask

   task automatic test_done_edges();
      press(4'd10);
      press(4'd1);
      fire_eq();
      pressed = 1'b0;
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      tests++;
      if ({state, state_disp, err} !== 4'b1110) begin
         fails++;
         $display("FAIL early_done got st=%b d=%b e=%b exp 11 1 0", state, state_disp, err);
      end
      press(4'd2);
      press(4'd12);
      press(4'd3);
      fire_eq();
      pressed = 1'b0;
      repeat (7) tick();
      tests++;
      if (state !== 2'b10) begin fails++; $display("FAIL last_wait got %b exp 10", state); end
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      tests++;
      if ({state, err} !== 3'b110) begin
         fails++;
         $display("FAIL done_vs_to got st=%b e=%b exp 11 0", state, err);
      end
      tests++;
      if ({numA, numB, calculation} !== {8'h02, 8'h03, 2'b10}) begin
         fails++;
         $display("FAIL mul_ops got A=%h B=%h c=%b exp 02 03 10", numA, numB, calculation);
      end
   endtask

   task automatic test_clear_vs_done();
      press(4'd1);
      press(4'd10);
      press(4'd2);
      fire_eq();
      pressed = 1'b0;
      tick();
      key = 4'd15;
      pressed = 1'b1;
      repeat (HOLD - 1) tick();
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      pressed = 1'b0;
      tests++;
      if ({numA, numB, calculation, calc_start, state, state_disp, err} !== 23'd0) begin
         fails++;
         $display("FAIL clr_done got A=%h B=%h c=%b s=%b st=%b d=%b e=%b exp all zero",
                  numA, numB, calculation, calc_start, state, state_disp, err);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      press(4'd3);
      press(4'd11);
      key = 4'd13;
      pressed = 1'b1;
      rst = 1'b1;
      repeat (HOLD) tick();
      tests++;
      if ({calc_start, state, numA, calculation} !== 13'd0) begin
         fails++;
         $display("FAIL rst_mid got s=%b st=%b A=%h c=%b exp 0 00 00 00",
                  calc_start, state, numA, calculation);
      end
      rst = 1'b0;
      pressed = 1'b0;
      tick();
      tests++;
      if (calc_start !== 1'b0) begin fails++; $display("FAIL rst_residual got %b exp 0", calc_start); end
   endtask

`ifdef KEY_DEBOUNCE_EN
   task automatic test_debounce();
      press(4'd15);
      key = 4'd2;
      pressed = 1'b1;
      repeat (3) tick();
      pressed = 1'b0;
      repeat (2) tick();
      tests++;
      if (numA !== 8'h00) begin fails++; $display("FAIL db_glitch got %h exp 00", numA); end
      pressed = 1'b1;
      repeat (4) tick();
      tests++;
      if (numA !== 8'h02) begin fails++; $display("FAIL db_press got %h exp 02", numA); end
      pressed = 1'b0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic_add();
      test_res_digit();
      test_held_key();
      test_overflow();
      test_timeout();
      test_done_edges();
      test_clear_vs_done();
      test_reset_mid();
`ifdef KEY_DEBOUNCE_EN
      test_debounce();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
